clock_time_core: RTL
====================

# clock_time_core

Parametrised time-of-day core for the seven-segment clock. It keeps hours, minutes and seconds from a programmable clock divider. It supports 12- and 24-hour presentation and an in-place set mode driven by debounced, single-cycle key pulses. It presents packed BCD digits, a field-select code and a blink phase to the display driver, replacing the fixed 16-bit-divider, binary-only time counters.

## Interface
Parameters:
- TICK_DIV, 65536, clock cycles per second; legal range 2 to 2^24; divider width is ceil(log2(TICK_DIV))
- START_HOUR, 0, hour (0-23) loaded on reset

Ports:
- clock  in  1  single design clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset; overrides all other inputs
- key_mode  in  1  debounced one-cycle pulse; advances the set-mode FSM
- key_add  in  1  debounced one-cycle pulse; increments the field being edited
- mode_12h  in  1  1 = 12-hour presentation, 0 = 24-hour; display only, never alters stored time
- hour_bcd  out  8  two BCD digits, tens in [7:4]
- minute_bcd  out  8  two BCD digits
- second_bcd  out  8  two BCD digits
- pm  out  1  1 when mode_12h=1 and stored hour is 12-23; otherwise 0
- field_sel  out  2  0 = RUN, 1 = hour, 2 = minute, 3 = second being edited
- blink  out  1  blink phase for the edited field; 0 in RUN
- second_tick  out  1  one-cycle pulse on the cycle the seconds register advances

## Operation
- State: hour (5b binary, 0-23), minute (6b, 0-59), second (6b, 0-59), divider div (0 to TICK_DIV-1), FSM state.
- FSM states RUN, SET_HOUR, SET_MIN, SET_SEC. key_mode moves RUN->SET_HOUR->SET_MIN->SET_SEC->RUN, one step per pulse.
- div increments every cycle in all states and wraps from TICK_DIV-1 to 0.
- On the transition SET_SEC->RUN, div is forced to 0 so the first second after setting is a full TICK_DIV cycles.
- tick = (div == TICK_DIV-1) and state == RUN. On tick, second increments.
  - 59 wraps to 0 and carries into minute on the same edge.
  - minute 59 wraps to 0 and carries into hour on the same edge.
  - hour 23 wraps to 0.
- In the SET states, tick is suppressed and time is frozen apart from edits.
- key_add in SET_HOUR: hour+1, 23 wraps to 0. In SET_MIN: minute+1, 59 wraps to 0. In SET_SEC: second+1, 59 wraps to 0. Edits never carry into the next field. key_add in RUN is ignored.
- key_mode and key_add in the same cycle: key_mode takes effect and key_add is discarded.
- 12-hour mapping, driven by mode_12h:
  - stored 0 shows 12 with pm=0
  - stored 1-11 shows 1-11 with pm=0
  - stored 12 shows 12 with pm=1
  - stored 13-23 shows 1-11 with pm=1
- BCD conversion is exact for 0-59. Tens digit is at most 5 for minute/second and at most 2 for hour.
- blink = (div < TICK_DIV/2, integer division) when in a SET state, else 0.

## Timing
- All time registers and the FSM are registered. hour_bcd, minute_bcd, second_bcd, pm, field_sel and blink are combinational decodes of registered state, with no additional latency.
- An edit or tick is visible on the outputs in the cycle following the triggering edge.
- second_tick is high for exactly the one cycle in which tick is true. It is never asserted in the SET states.
- Reset values: hour = START_HOUR, minute = 0, second = 0, div = 0, state RUN. Outputs at reset: field_sel = 0, blink = 0, second_tick = 0, minute_bcd = 0x00, second_bcd = 0x00, hour_bcd = BCD of START_HOUR under the current mode_12h.
- Reset asserted mid-edit returns to RUN with reset values on the next edge. Any pending key pulse in that cycle is discarded.
- After reset deassertion, the first second_tick occurs TICK_DIV cycles after the first non-reset edge.
- A mode_12h change affects only the combinational outputs, in the same cycle.

## Test plan
- TICK_DIV=4, reset for 2 cycles, then run: outputs 00/00/00 with field_sel=0; second_tick pulses every 4th cycle; second_bcd reads 0x01 after the first pulse and reaches 0x10 after the tenth.
- Set time to 23:59:59 via the SET states, return to RUN, run 4 cycles: all fields read 0x00 after the single tick; minute and hour carry on that same edge.
- Stored hours 0, 11, 12, 13, 23 with mode_12h=1 -> hour_bcd/pm = 0x12/0, 0x11/0, 0x12/1, 0x01/1, 0x11/1; with mode_12h=0 -> 0x00, 0x11, 0x12, 0x13, 0x23, pm=0 throughout.
- key_mode once, then 25 key_add pulses -> hour = 1 (wrap at 24), field_sel=1, no second_tick during the sequence, and blink toggles with a period of TICK_DIV.
- In SET_MIN at minute 59, assert key_mode and key_add in the same cycle -> state SET_SEC, minute stays 59; a further key_add in SET_SEC at second 59 -> second 0 with minute still 59.
- Assert reset during SET_MIN with a key_add pulse in the same cycle -> next cycle field_sel=0, time = START_HOUR:00:00, no edit applied.

Source files
------------

// File: rtl/clock_time_core.sv
// Time-of-day core: divider-driven h/m/s counters, set-mode FSM, and BCD/12h display decode.
// The display outputs are combinational decodes of registered state.
module clock_time_core #(
  parameter int TICK_DIV   = 65536,
  parameter int START_HOUR = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_add,
  input  logic       mode_12h,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic       pm,
  output logic [1:0] field_sel,
  output logic       blink,
  output logic       second_tick
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  // Field-select code is taken directly from the state encoding.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_hour;
  logic [5:0]       r_min;
  logic [5:0]       r_sec;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       w_hour_nxt;
  logic [5:0]       w_min_nxt;
  logic [5:0]       w_sec_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [4:0]       w_hour_disp;
  logic             w_tick;

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    if (v >= 6'd50)      tens = 4'd5;
    else if (v >= 6'd40) tens = 4'd4;
    else if (v >= 6'd30) tens = 4'd3;
    else if (v >= 6'd20) tens = 4'd2;
    else if (v >= 6'd10) tens = 4'd1;
    else                 tens = 4'd0;
    return {tens, 4'(v - 6'(tens) * 6'd10)};
  endfunction

  assign w_tick = (r_state == ST_RUN) && (r_div == DIV_MAX);

  // Next-state and next-time computation; key_mode has priority over key_add.
  always_comb begin
    w_state_nxt = r_state;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_div_nxt   = (r_div == DIV_MAX) ? DIV_ZERO : r_div + DIV_ONE;
    case (r_state)
      ST_RUN: begin
        if (key_mode) w_state_nxt = ST_SET_HOUR;
        else          w_state_nxt = ST_RUN;
        if (w_tick) begin
          w_sec_nxt = inc_mod60(r_sec);
          if (r_sec == 6'd59) begin
            w_min_nxt = inc_mod60(r_min);
            if (r_min == 6'd59) w_hour_nxt = inc_mod24(r_hour);
            else                w_hour_nxt = r_hour;
          end else begin
            w_min_nxt = r_min;
          end
        end else begin
          w_sec_nxt = r_sec;
        end
      end
      ST_SET_HOUR: begin
        if (key_mode)     w_state_nxt = ST_SET_MIN;
        else if (key_add) w_hour_nxt  = inc_mod24(r_hour);
        else              w_hour_nxt  = r_hour;
      end
      ST_SET_MIN: begin
        if (key_mode)     w_state_nxt = ST_SET_SEC;
        else if (key_add) w_min_nxt   = inc_mod60(r_min);
        else              w_min_nxt   = r_min;
      end
      ST_SET_SEC: begin
        // Restart the divider so the first second after setting is full length.
        if (key_mode) begin
          w_state_nxt = ST_RUN;
          w_div_nxt   = DIV_ZERO;
        end else if (key_add) begin
          w_sec_nxt = inc_mod60(r_sec);
        end else begin
          w_sec_nxt = r_sec;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Time and divider registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hour <= 5'(START_HOUR);
      r_min  <= 6'd0;
      r_sec  <= 6'd0;
      r_div  <= DIV_ZERO;
    end else begin
      r_hour <= w_hour_nxt;
      r_min  <= w_min_nxt;
      r_sec  <= w_sec_nxt;
      r_div  <= w_div_nxt;
    end
  end

  // 12-hour mapping: 0 shows as 12, 13-23 show as 1-11.
  always_comb begin
    w_hour_disp = r_hour;
    if (mode_12h) begin
      if (r_hour == 5'd0)       w_hour_disp = 5'd12;
      else if (r_hour > 5'd12)  w_hour_disp = r_hour - 5'd12;
      else                      w_hour_disp = r_hour;
    end else begin
      w_hour_disp = r_hour;
    end
  end

  assign hour_bcd    = to_bcd({1'b0, w_hour_disp});
  assign minute_bcd  = to_bcd(r_min);
  assign second_bcd  = to_bcd(r_sec);
  assign pm          = mode_12h && (r_hour >= 5'd12);
  assign field_sel   = r_state;
  assign blink       = (r_state != ST_RUN) && (r_div < DIV_HALF);
  assign second_tick = w_tick;

endmodule
